// File: rtl/fp_addsub_arbiter.sv
// rtl/fp_addsub_arbiter.sv - two-requester round-robin arbiter sharing one add/sub datapath
// Result register is a single slot; the winner is accepted whenever that slot is empty or draining.
module fp_addsub_arbiter #(
  parameter int SIZE_DATA = 28
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req0_valid,
  output logic                 o_req0_ready,
  input  logic                 i_req0_op,
  input  logic [SIZE_DATA-1:0] i_req0_a,
  input  logic [SIZE_DATA-1:0] i_req0_b,
  input  logic                 i_req1_valid,
  output logic                 o_req1_ready,
  input  logic                 i_req1_op,
  input  logic [SIZE_DATA-1:0] i_req1_a,
  input  logic [SIZE_DATA-1:0] i_req1_b,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic                 o_res_tag,
  output logic [SIZE_DATA-1:0] o_res_data,
  output logic                 o_res_carry
);

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_prio;
  logic                  r_res_tag;
  logic                  r_res_carry;
  logic [SIZE_DATA-1:0]  r_res_data;

  logic                  w_slot_free;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_xfer0;
  logic                  w_xfer1;
  logic                  w_xfer;
  logic                  w_op;
  logic [SIZE_DATA-1:0]  w_a;
  logic [SIZE_DATA-1:0]  w_b;
  logic [SIZE_DATA-1:0]  w_b_eff;
  logic [SIZE_DATA:0]    w_sum;

  // r_prio: 0 = requester 0 wins a tie, 1 = requester 1 wins a tie.
  assign w_slot_free = (r_state == S_IDLE) || i_res_ready;
  assign w_grant0    = i_req0_valid && (!i_req1_valid || !r_prio);
  assign w_grant1    = i_req1_valid && (!i_req0_valid ||  r_prio);

  assign o_req0_ready = i_rst_n && w_slot_free && w_grant0;
  assign o_req1_ready = i_rst_n && w_slot_free && w_grant1;

  assign w_xfer0 = i_req0_valid && o_req0_ready;
  assign w_xfer1 = i_req1_valid && o_req1_ready;
  assign w_xfer  = w_xfer0 || w_xfer1;

  assign w_op    = w_xfer1 ? i_req1_op : i_req0_op;
  assign w_a     = w_xfer1 ? i_req1_a  : i_req0_a;
  assign w_b     = w_xfer1 ? i_req1_b  : i_req0_b;
  // Subtract as a + ~b + 1; the carry out then reads as "no borrow".
  assign w_b_eff = w_op ? ~w_b : w_b;
  assign w_sum   = {1'b0, w_a} + {1'b0, w_b_eff} + {{SIZE_DATA{1'b0}}, w_op};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer) w_state_nxt = S_HOLD;
      S_HOLD:  if (i_res_ready && !w_xfer) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_prio      <= 1'b0;
      r_res_tag   <= 1'b0;
      r_res_carry <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_prio      <= ~w_xfer1;
        r_res_tag   <= w_xfer1;
        r_res_carry <= w_sum[SIZE_DATA];
        r_res_data  <= w_sum[SIZE_DATA-1:0];
      end
    end
  end

  assign o_res_valid = (r_state == S_HOLD);
  assign o_res_tag   = r_res_tag;
  assign o_res_carry = r_res_carry;
  assign o_res_data  = r_res_data;

endmodule
